sprite_line_matcher: RTL

- Parametrised successor of the per-line sprite matcher in the draw domain.
- On each `line` pulse it scans the sprite attribute table for sprites covering the lookahead scanline (current line + 2).
- Matches are stored in a ring-buffered active list, capped per line, with an overflow flag.
- During the following line the list is exposed to the tile fetcher as line N+1 data via an indexed read port with 1-cycle latency.

---
 rtl/sprite_match_pkg.sv | 59 +++++
 rtl/sprite_line_matcher_if.sv | 32 +++
 rtl/active_ring_ram.sv | 36 +++
 rtl/sprite_line_matcher.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/sprite_match_pkg.sv
// sprite_match_pkg -- shared types, default widths and the scanline match function
// Rev 1.0
`default_nettype none

package sprite_match_pkg;

   localparam int DEF_NUM_SPRITES  = 512;
   localparam int DEF_MAX_PER_LINE = 64;
   localparam int DEF_ACTIVE_DEPTH = 128;
   localparam int DEF_Y_W          = 11;
   localparam int DEF_H_W          = 4;
   localparam int DEF_TILE_H_LOG2  = 4;

   localparam int DEF_IDX_W = $clog2(DEF_NUM_SPRITES);
   localparam int DEF_ACT_W = $clog2(DEF_ACTIVE_DEPTH);
   localparam int DEF_ROW_W = DEF_H_W + DEF_TILE_H_LOG2;
   localparam int DEF_CNT_W = $clog2(DEF_MAX_PER_LINE + 1);

   localparam int ENTRY_ID_W  = 16;
   localparam int ENTRY_ROW_W = 16;
   localparam int MATCH_W     = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic [ENTRY_ID_W-1:0]  sprite_id;
      logic [ENTRY_ROW_W-1:0] row;
   } active_entry_t;

   typedef struct packed {
      logic               hit;
      logic [MATCH_W-1:0] row;
   } match_res_t;

   // Wide arithmetic so y + span can never wrap for any legal field widths.
   function automatic match_res_t sprite_match(
      input logic [MATCH_W-1:0] sy,
      input logic [MATCH_W-1:0] y,
      input logic [MATCH_W-1:0] height,
      input int                 tile_log2,
      input logic               flip
   );
      logic [MATCH_W-1:0] span;
      logic [MATCH_W-1:0] row;
      match_res_t         res;
      span    = height << tile_log2;
      res.hit = (height != '0) && (sy >= y) && (sy < (y + span));
      row     = sy - y;
      res.row = flip ? (span - 32'd1 - row) : row;
      return res;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sprite_line_matcher_if.sv
// sprite_line_matcher_if -- indexed read port of the line N+1 active list
// Rev 1.0
`default_nettype none

interface sprite_line_matcher_if
   import sprite_match_pkg::*;
#(
   parameter int ACT_W = DEF_ACT_W,
   parameter int IDX_W = DEF_IDX_W,
   parameter int ROW_W = DEF_ROW_W,
   parameter int CNT_W = DEF_CNT_W
);
   logic [ACT_W-1:0] rd_index;
   logic             rd_valid;
   logic [IDX_W-1:0] rd_sprite;
   logic [ROW_W-1:0] rd_row;
   logic [CNT_W-1:0] rd_count;
   logic             rd_overflow;
   logic             rd_incomplete;

   modport master (
      output rd_index,
      input  rd_valid, rd_sprite, rd_row, rd_count, rd_overflow, rd_incomplete
   );

   modport slave (
      input  rd_index,
      output rd_valid, rd_sprite, rd_row, rd_count, rd_overflow, rd_incomplete
   );
endinterface

`default_nettype wire

// File: rtl/active_ring_ram.sv
// active_ring_ram -- simple dual-port RAM, one write and one registered read port
// Rev 1.0
`default_nettype none

module active_ring_ram #(
   parameter  int DEPTH  = 128,
   parameter  int WIDTH  = 32,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Output register reset maps onto the block-RAM output latch reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata <= '0;
      end else begin
         rdata <= mem[raddr];
      end
   end
endmodule

`default_nettype wire

// File: rtl/sprite_line_matcher.sv
// sprite_line_matcher -- per-line attribute scan into a ring-buffered active list
// Rev 1.0
`default_nettype none

module sprite_line_matcher
   import sprite_match_pkg::*;
#(
   parameter  int NUM_SPRITES  = DEF_NUM_SPRITES,
   parameter  int MAX_PER_LINE = DEF_MAX_PER_LINE,
   parameter  int ACTIVE_DEPTH = DEF_ACTIVE_DEPTH,
   parameter  int Y_W          = DEF_Y_W,
   parameter  int H_W          = DEF_H_W,
   parameter  int TILE_H_LOG2  = DEF_TILE_H_LOG2,
   localparam int IDX_W        = $clog2(NUM_SPRITES),
   localparam int ACT_W        = $clog2(ACTIVE_DEPTH),
   localparam int ROW_W        = H_W + TILE_H_LOG2,
   localparam int CNT_W        = $clog2(MAX_PER_LINE + 1)
) (
   input  logic             clk_draw,
   input  logic             rst_draw_n,
   input  logic             enable,
   input  logic             line,
   input  logic [Y_W-1:0]   sy_plus2,
   output logic [IDX_W-1:0] attr_index,
   input  logic [Y_W-1:0]   attr_y,
   input  logic [H_W-1:0]   attr_height,
   input  logic             attr_y_flip,
   output logic             scan_busy,
   sprite_line_matcher_if.slave rd
);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);
   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PER_LINE);
   localparam int               CMP_W    = (ACT_W > CNT_W) ? ACT_W : CNT_W;

   if ((ACTIVE_DEPTH < 2 * MAX_PER_LINE) || ((ACTIVE_DEPTH & (ACTIVE_DEPTH - 1)) != 0) ||
       (NUM_SPRITES < 2) || (MAX_PER_LINE < 1) || (IDX_W > ENTRY_ID_W) ||
       (ROW_W > ENTRY_ROW_W) || (Y_W + ROW_W + 1 > MATCH_W)) begin : g_bad_params
      $error("sprite_line_matcher: illegal parameter combination");
   end

   state_t           state;
   state_t           state_nxt;
   logic [Y_W-1:0]   sy;
   logic             eval_valid;
   logic [IDX_W-1:0] eval_id;
   logic [ACT_W-1:0] wr_ptr;
   logic [ACT_W-1:0] p1_start;
   logic [ACT_W-1:0] p2_start;
   logic [ACT_W-1:0] rd_addr;
   logic [CNT_W-1:0] p2_count;
   logic             p2_overflow;
   match_res_t       mres;
   logic             hit;
   logic             room;
   logic             accept;
   logic             drop;
   logic             wr_en;
   logic [ROW_W-1:0] row;
   active_entry_t    wr_entry;
   active_entry_t    rd_entry;
   logic             unused_hi;

   always_ff @(posedge clk_draw) begin
      if (!rst_draw_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  state_nxt = ST_IDLE;
         ST_SCAN:  if (attr_index == LAST_IDX) state_nxt = ST_DRAIN;
         ST_DRAIN: state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
      if (line) begin
         state_nxt = ST_SCAN;
      end
   end

   assign scan_busy = (state != ST_IDLE);

   // Data returned in a line cycle belongs to the old scan, so eval_valid drops.
   always_ff @(posedge clk_draw) begin
      if (!rst_draw_n) begin
         sy         <= '0;
         attr_index <= '0;
         eval_valid <= 1'b0;
         eval_id    <= '0;
      end else begin
         eval_valid <= (state == ST_SCAN) && !line;
         eval_id    <= attr_index;
         if (line) begin
            sy         <= sy_plus2;
            attr_index <= '0;
         end else if ((state == ST_SCAN) && (attr_index != LAST_IDX)) begin
            attr_index <= attr_index + IDX_W'(1);
         end
      end
   end

   assign mres   = sprite_match(MATCH_W'(sy), MATCH_W'(attr_y), MATCH_W'(attr_height),
                                TILE_H_LOG2, attr_y_flip);
   assign row    = mres.row[ROW_W-1:0];
   assign hit    = enable & eval_valid & mres.hit & ~line;
   assign room   = (p2_count < MAX_CNT);
   assign accept = hit & room;
   assign drop   = hit & ~room;
   assign wr_en  = accept & rst_draw_n;

   always_comb begin
      wr_entry           = '0;
      wr_entry.sprite_id = ENTRY_ID_W'(eval_id);
      wr_entry.row       = ENTRY_ROW_W'(row);
   end

   always_ff @(posedge clk_draw) begin
      if (!rst_draw_n) begin
         wr_ptr           <= '0;
         p1_start         <= '0;
         p2_start         <= '0;
         p2_count         <= '0;
         p2_overflow      <= 1'b0;
         rd.rd_count      <= '0;
         rd.rd_overflow   <= 1'b0;
         rd.rd_incomplete <= 1'b0;
      end else if (line) begin
         p1_start         <= p2_start;
         p2_start         <= wr_ptr;
         rd.rd_count      <= p2_count;
         rd.rd_overflow   <= p2_overflow;
         rd.rd_incomplete <= (state != ST_IDLE);
         p2_count         <= '0;
         p2_overflow      <= 1'b0;
      end else begin
         if (accept) begin
            wr_ptr   <= wr_ptr + ACT_W'(1);
            p2_count <= p2_count + CNT_W'(1);
         end
         if (drop) begin
            p2_overflow <= 1'b1;
         end
      end
   end

   assign rd_addr = p1_start + rd.rd_index;

   always_ff @(posedge clk_draw) begin
      if (!rst_draw_n || line) begin
         rd.rd_valid <= 1'b0;
      end else begin
         rd.rd_valid <= (CMP_W'(rd.rd_index) < CMP_W'(rd.rd_count));
      end
   end

   active_ring_ram #(
      .DEPTH (ACTIVE_DEPTH),
      .WIDTH ($bits(active_entry_t))
   ) u_ring (
      .clk   (clk_draw),
      .rst_n (rst_draw_n),
      .we    (wr_en),
      .waddr (wr_ptr),
      .wdata (wr_entry),
      .raddr (rd_addr),
      .rdata (rd_entry)
   );

   assign rd.rd_sprite = rd_entry.sprite_id[IDX_W-1:0];
   assign rd.rd_row    = rd_entry.row[ROW_W-1:0];
   assign unused_hi    = ^{mres.row >> ROW_W, rd_entry.sprite_id >> IDX_W, rd_entry.row >> ROW_W};
endmodule

`default_nettype wire
